// File: rtl/axi_4_lite_req_arbiter_pkg.sv
// Shared AXI4-Lite widths, response codes and arbiter FSM encodings.
package axi_4_lite_req_arbiter_pkg;

  localparam int C_AXI_ADDR_WIDTH = 32;
  localparam int C_AXI_DATA_WIDTH = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ARB_ST_IDLE    = 3'd0,
    ARB_ST_WR_ADDR = 3'd1,
    ARB_ST_WR_RESP = 3'd2,
    ARB_ST_RD_ADDR = 3'd3,
    ARB_ST_RD_DATA = 3'd4,
    ARB_ST_DONE    = 3'd5
  } arb_state_e;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_4_lite_rr_picker.sv
// Combinational round-robin picker: first requester at or above the pointer,
// wrapping modulo NUM_REQ, wins.
module axi_4_lite_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  int   cand;
  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IDX_W'(cand);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/axi_4_lite_req_arbiter.sv
// Round-robin arbiter turning NUM_REQ single-beat register requests into
// AXI4-Lite transactions, one outstanding at a time.
module axi_4_lite_req_arbiter
  import axi_4_lite_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = C_AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = C_AXI_DATA_WIDTH
) (
  input  logic                             M_AXI_ACLK,
  input  logic                             M_AXI_ARESET,
  input  logic [NUM_REQ-1:0]               REQ_VALID,
  input  logic [NUM_REQ-1:0]               REQ_WRITE,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    REQ_ADDR,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    REQ_WDATA,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  REQ_WSTRB,
  output logic [NUM_REQ-1:0]               REQ_DONE,
  output logic [DATA_WIDTH-1:0]            RSP_RDATA,
  output logic                             RSP_ERR,
  output logic                             M_AXI_AWVALID,
  input  logic                             M_AXI_AWREADY,
  output logic [ADDR_WIDTH-1:0]            M_AXI_AWADDR,
  output logic [2:0]                       M_AXI_AWPROT,
  output logic                             M_AXI_WVALID,
  input  logic                             M_AXI_WREADY,
  output logic [DATA_WIDTH-1:0]            M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]          M_AXI_WSTRB,
  input  logic                             M_AXI_BVALID,
  output logic                             M_AXI_BREADY,
  input  logic [1:0]                       M_AXI_BRESP,
  output logic                             M_AXI_ARVALID,
  input  logic                             M_AXI_ARREADY,
  output logic [ADDR_WIDTH-1:0]            M_AXI_ARADDR,
  output logic [2:0]                       M_AXI_ARPROT,
  input  logic                             M_AXI_RVALID,
  output logic                             M_AXI_RREADY,
  input  logic [DATA_WIDTH-1:0]            M_AXI_RDATA,
  input  logic [1:0]                       M_AXI_RRESP
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W      = $clog2(NUM_REQ);

  arb_state_e              state_q;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [NUM_REQ-1:0]      gnt_q, done_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic                    awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, err_q;

  logic [NUM_REQ-1:0]      pick_gnt;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_any;
  logic                    aw_fin, w_fin;

  axi_4_lite_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req_i (REQ_VALID),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign ptr_d  = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
  // AW and W may complete in either order; each is finished once its VALID is gone or accepted now.
  assign aw_fin = ~awvalid_q | M_AXI_AWREADY;
  assign w_fin  = ~wvalid_q  | M_AXI_WREADY;

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_q   <= ARB_ST_IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      done_q <= '0;
      case (state_q)
        ARB_ST_IDLE: begin
          if (pick_any) begin
            gnt_q  <= pick_gnt;
            ptr_q  <= ptr_d;
            addr_q <= REQ_ADDR[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            if (REQ_WRITE[pick_idx]) begin
              wdata_q   <= REQ_WDATA[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
              wstrb_q   <= REQ_WSTRB[int'(pick_idx)*STRB_WIDTH +: STRB_WIDTH];
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ARB_ST_WR_ADDR;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= ARB_ST_RD_ADDR;
            end
          end
        end
        ARB_ST_WR_ADDR: begin
          if (M_AXI_AWREADY) awvalid_q <= 1'b0;
          if (M_AXI_WREADY)  wvalid_q  <= 1'b0;
          if (aw_fin && w_fin) begin
            bready_q <= 1'b1;
            state_q  <= ARB_ST_WR_RESP;
          end
        end
        ARB_ST_WR_RESP: begin
          if (M_AXI_BVALID) begin
            bready_q <= 1'b0;
            err_q    <= resp_is_err(M_AXI_BRESP);
            rdata_q  <= '0;
            done_q   <= gnt_q;
            state_q  <= ARB_ST_DONE;
          end
        end
        ARB_ST_RD_ADDR: begin
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ARB_ST_RD_DATA;
          end
        end
        ARB_ST_RD_DATA: begin
          if (M_AXI_RVALID) begin
            rready_q <= 1'b0;
            err_q    <= resp_is_err(M_AXI_RRESP);
            rdata_q  <= M_AXI_RDATA;
            done_q   <= gnt_q;
            state_q  <= ARB_ST_DONE;
          end
        end
        ARB_ST_DONE: state_q <= ARB_ST_IDLE;
        default:     state_q <= ARB_ST_IDLE;
      endcase
    end
  end

  assign REQ_DONE      = done_q;
  assign RSP_RDATA     = rdata_q;
  assign RSP_ERR       = err_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_4_lite_req_arbiter.sv
// Directed bench for axi_4_lite_req_arbiter with a register-file slave model
// and an expected-completion queue.
module tb_axi_4_lite_req_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [N-1:0]    req_valid, req_write, req_done;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_wstrb;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;

  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rvalid, rready;
  logic [AW-1:0]   awaddr, araddr;
  logic [2:0]      awprot, arprot;
  logic [DW-1:0]   wdata, rdata;
  logic [SW-1:0]   wstrb;
  logic [1:0]      bresp, rresp;

  axi_4_lite_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESET  (rst),
    .REQ_VALID     (req_valid),
    .REQ_WRITE     (req_write),
    .REQ_ADDR      (req_addr),
    .REQ_WDATA     (req_wdata),
    .REQ_WSTRB     (req_wstrb),
    .REQ_DONE      (req_done),
    .RSP_RDATA     (rsp_rdata),
    .RSP_ERR       (rsp_err),
    .M_AXI_AWVALID (awvalid),
    .M_AXI_AWREADY (awready),
    .M_AXI_AWADDR  (awaddr),
    .M_AXI_AWPROT  (awprot),
    .M_AXI_WVALID  (wvalid),
    .M_AXI_WREADY  (wready),
    .M_AXI_WDATA   (wdata),
    .M_AXI_WSTRB   (wstrb),
    .M_AXI_BVALID  (bvalid),
    .M_AXI_BREADY  (bready),
    .M_AXI_BRESP   (bresp),
    .M_AXI_ARVALID (arvalid),
    .M_AXI_ARREADY (arready),
    .M_AXI_ARADDR  (araddr),
    .M_AXI_ARPROT  (arprot),
    .M_AXI_RVALID  (rvalid),
    .M_AXI_RREADY  (rready),
    .M_AXI_RDATA   (rdata),
    .M_AXI_RRESP   (rresp)
  );

  always #5 clk = ~clk;

  // Register-file slave: registered READY/VALID with programmable stalls.
  logic [31:0] mem [0:15];
  int          aw_delay = 0, w_delay = 0, r_delay = 0;
  logic        err_inj = 1'b0;
  int          aw_wait, w_wait, r_wait;
  logic        aw_got, w_got, ar_got, bready_prev;
  logic [31:0] aw_addr_l, w_data_l, ar_addr_l;
  logic [3:0]  w_strb_l;
  int          aw_hs = 0, w_hs = 0, bready_rises = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
      arready <= 1'b0; rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
      aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0; bready_prev = 1'b0;
      aw_wait = 0; w_wait = 0; r_wait = 0;
    end else begin
      if (bready && !bready_prev) bready_rises++;
      bready_prev = bready;
      if (awvalid && awready) begin
        awready <= 1'b0; aw_got = 1'b1; aw_addr_l = awaddr; aw_hs++; aw_wait = 0;
      end else if (awvalid && !awready && !aw_got) begin
        if (aw_wait >= aw_delay) awready <= 1'b1; else aw_wait++;
      end
      if (wvalid && wready) begin
        wready <= 1'b0; w_got = 1'b1; w_data_l = wdata; w_strb_l = wstrb; w_hs++; w_wait = 0;
      end else if (wvalid && !wready && !w_got) begin
        if (w_wait >= w_delay) wready <= 1'b1; else w_wait++;
      end
      if (aw_got && w_got && !bvalid) begin
        if (!err_inj)
          for (int b = 0; b < 4; b++)
            if (w_strb_l[b]) mem[aw_addr_l[5:2]][8*b +: 8] = w_data_l[8*b +: 8];
        bvalid <= 1'b1; bresp <= err_inj ? 2'b10 : 2'b00;
        aw_got = 1'b0; w_got = 1'b0;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
      if (arvalid && arready) begin
        arready <= 1'b0; ar_got = 1'b1; ar_addr_l = araddr; r_wait = 0;
      end else if (arvalid && !arready && !ar_got) begin
        arready <= 1'b1;
      end
      if (ar_got && !rvalid) begin
        if (r_wait >= r_delay) begin
          rvalid <= 1'b1; rdata <= mem[ar_addr_l[5:2]]; rresp <= err_inj ? 2'b10 : 2'b00;
          ar_got = 1'b0;
        end else r_wait++;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  typedef struct {
    int          client;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   pend[N];
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int c, input logic [31:0] d, input logic e);
    exp_t x;
    x.client = c; x.rdata = d; x.err = e;
    sbq.push_back(x);
  endtask

  task automatic set_req(input int c, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, input int n);
    req_write[c]           = wr;
    req_addr[c*AW +: AW]   = a;
    req_wdata[c*DW +: DW]  = d;
    req_wstrb[c*SW +: SW]  = s;
    pend[c]                = n;
    req_valid[c]           = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    exp_t x;
    bit   seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (req_done != '0) seen = 1'b1;
    end
    n_cmp++;
    assert (seen) else begin
      n_bad++;
      $error("FAIL %s timeout: observed no REQ_DONE within 60 cycles, expected one", tag);
    end
    if (!seen) return;
    n_cmp++;
    assert (sbq.size() != 0) else begin
      n_bad++;
      $error("FAIL %s extra: observed REQ_DONE %b, expected none queued", tag, req_done);
    end
    if (sbq.size() == 0) return;
    x = sbq.pop_front();
    chk({tag, " grant"}, 32'(req_done), 32'(1 << x.client));
    chk({tag, " rdata"}, rsp_rdata, x.rdata);
    chk({tag, " err"}, 32'(rsp_err), 32'(x.err));
    for (int k = 0; k < N; k++)
      if (req_done[k]) begin
        pend[k]--;
        if (pend[k] <= 0) req_valid[k] = 1'b0;
      end
    @(negedge clk);
    chk({tag, " pulse"}, 32'(req_done), 32'h0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " ctl"}, 32'({awvalid, wvalid, bready, arvalid, rready, req_done, rsp_err}), 32'h0);
    chk({tag, " rdata"}, rsp_rdata, 32'h0);
    chk({tag, " bus"}, awaddr | araddr | wdata | 32'(wstrb), 32'h0);
  endtask

  initial begin
    logic [N-1:0] done_or;
    int           a0, w0, b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    pend[0] = 0; pend[1] = 0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single client write then readback.
    push_exp(0, 32'h0, 1'b0);
    set_req(0, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 1);
    wait_done("t1_wr");
    push_exp(0, 32'hDEADBEEF, 1'b0);
    set_req(0, 1'b0, 32'h4, 32'h0, 4'h0, 1);
    wait_done("t1_rd");
    push_exp(1, 32'hDEADBEEF, 1'b0);
    set_req(1, 1'b0, 32'h4, 32'h0, 4'h0, 1);
    wait_done("c1_rd");

    // Simultaneous writes with pointer at 0: client 0 first, then client 1.
    push_exp(0, 32'h0, 1'b0);
    push_exp(1, 32'h0, 1'b0);
    set_req(0, 1'b1, 32'h0, 32'h11111111, 4'hF, 1);
    set_req(1, 1'b1, 32'h0, 32'h22222222, 4'hF, 1);
    wait_done("t2_c0");
    wait_done("t2_c1");
    push_exp(1, 32'h22222222, 1'b0);
    set_req(1, 1'b0, 32'h0, 32'h0, 4'h0, 1);
    wait_done("t2_rd");

    push_exp(0, 32'h0, 1'b0);
    set_req(0, 1'b1, 32'h8, 32'hA0A0A0A0, 4'hF, 1);
    wait_done("pre_a");
    push_exp(1, 32'h0, 1'b0);
    set_req(1, 1'b1, 32'hC, 32'hB0B0B0B0, 4'hF, 1);
    wait_done("pre_b");

    // Back-to-back reads from both clients must alternate grants.
    for (int i = 0; i < 3; i++) begin
      push_exp(0, 32'hA0A0A0A0, 1'b0);
      push_exp(1, 32'hB0B0B0B0, 1'b0);
    end
    set_req(0, 1'b0, 32'h8, 32'h0, 4'h0, 3);
    set_req(1, 1'b0, 32'hC, 32'h0, 4'h0, 3);
    for (int i = 0; i < 6; i++) wait_done("t3_alt");

    // WREADY three cycles ahead of AWREADY.
    aw_delay = 3;
    a0 = aw_hs; w0 = w_hs; b0 = bready_rises;
    push_exp(0, 32'h0, 1'b0);
    set_req(0, 1'b1, 32'h10, 32'h12345678, 4'hF, 1);
    wait_done("t4_wr");
    done_or = '0;
    repeat (4) begin @(negedge clk); done_or = done_or | req_done; end
    chk("t4 no_extra_done", 32'(done_or), 32'h0);
    chk("t4 aw_handshakes", 32'(aw_hs - a0), 32'd1);
    chk("t4 w_handshakes", 32'(w_hs - w0), 32'd1);
    chk("t4 bready_pulses", 32'(bready_rises - b0), 32'd1);
    aw_delay = 0;
    push_exp(1, 32'h12345678, 1'b0);
    set_req(1, 1'b0, 32'h10, 32'h0, 4'h0, 1);
    wait_done("t4_rd");

    // Partial strobes, then slave error responses.
    push_exp(0, 32'h0, 1'b0);
    set_req(0, 1'b1, 32'h0, 32'h0, 4'hF, 1);
    wait_done("t5_clr");
    push_exp(0, 32'h0, 1'b0);
    set_req(0, 1'b1, 32'h0, 32'hAABBCCDD, 4'b0101, 1);
    wait_done("t5_strb");
    push_exp(0, 32'h00BB00DD, 1'b0);
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0, 1);
    wait_done("t5_rd");
    err_inj = 1'b1;
    push_exp(0, 32'h0, 1'b1);
    set_req(0, 1'b1, 32'h14, 32'h55555555, 4'hF, 1);
    wait_done("t5_wr_err");
    push_exp(0, 32'h00BB00DD, 1'b1);
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0, 1);
    wait_done("t5_rd_err");
    err_inj = 1'b0;

    // Reset while waiting for RVALID aborts without a completion.
    r_delay = 8;
    set_req(0, 1'b0, 32'h4, 32'h0, 4'h0, 1);
    for (int i = 0; i < 20 && !rready; i++) @(negedge clk);
    chk("t6 in_rd_data", 32'(rready), 32'h1);
    #2 rst = 1'b1;
    #1 chk_quiet("t6_abort");
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    r_delay = 0;
    done_or = '0;
    repeat (6) begin @(negedge clk); done_or = done_or | req_done; end
    chk("t6 no_done_after_abort", 32'(done_or), 32'h0);
    push_exp(1, 32'hDEADBEEF, 1'b0);
    set_req(1, 1'b0, 32'h4, 32'h0, 4'h0, 1);
    wait_done("t6_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
